// File: rtl/seq_control_unit.sv
// rtl/seq_control_unit.sv - multi-cycle fetch/decode/execute sequencer for a register ALU datapath
module seq_control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic        MR_Read,
    output logic        pc_inc,
    output logic [3:0]  Control_Signals,
    output logic        done,
    output logic        err,
    output logic [15:0] instr_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;
    localparam logic [2:0] S_HALT = 3'd7;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;

    localparam logic [31:0] SEL_ZLO = 32'd19;
    localparam logic [31:0] SEL_PC  = 32'd20;
    localparam logic [31:0] SEL_MDR = 32'd21;
    localparam logic [31:0] SEL_IR  = 32'd23;
    localparam logic [31:0] SEL_Z   = 32'd24;
    localparam logic [31:0] SEL_MAR = 32'd25;
    localparam logic [31:0] SEL_Y   = 32'd27;

    // Wait count at which a still-idle memory is declared dead: this is the
    // 15th consecutive T1 cycle without mem_rdy.
    localparam logic [3:0] LAST_WAIT = 4'd14;

    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic [3:0]  wait_cnt_q;
    logic [4:0]  opcode_q;
    logic [3:0]  ra_q;
    logic [3:0]  rb_q;
    logic [3:0]  rc_q;
    logic [15:0] instr_cnt_q;
    logic [3:0]  alu_op;
    logic        op_legal;

    // The low instruction bits carry no fields this sequencer uses.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[14:0];

    // Map the latched opcode onto an ALU operation; anything else is illegal.
    always_comb begin
        alu_op   = 4'd0;
        op_legal = 1'b1;
        case (opcode_q)
            OP_ADD:  alu_op = 4'd1;
            OP_SUB:  alu_op = 4'd2;
            OP_AND:  alu_op = 4'd3;
            OP_OR:   alu_op = 4'd4;
            default: op_legal = 1'b0;
        endcase
    end

    // Next-state selection; run is only consulted in IDLE and T5.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = run ? S_T0 : S_IDLE;
            S_T0:   state_d = S_T1;
            S_T1: begin
                if (mem_rdy)
                    state_d = S_T2;
                else if (wait_cnt_q == LAST_WAIT)
                    state_d = S_HALT;
                else
                    state_d = S_T1;
            end
            S_T2:   state_d = S_T3;
            S_T3:   state_d = op_legal ? S_T4 : S_HALT;
            S_T4:   state_d = S_T5;
            S_T5:   state_d = run ? S_T0 : S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State register, memory wait counter, field latches and completion counter.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 4'd0;
            opcode_q    <= 5'd0;
            ra_q        <= 4'd0;
            rb_q        <= 4'd0;
            rc_q        <= 4'd0;
            instr_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            // Counter restarts on every fresh visit to T1.
            if (state_q == S_T1 && !mem_rdy)
                wait_cnt_q <= wait_cnt_q + 4'd1;
            else
                wait_cnt_q <= 4'd0;
            // Fields are captured while IR is being loaded so later ir changes are harmless.
            if (state_q == S_T2) begin
                opcode_q <= ir[31:27];
                ra_q     <= ir[26:23];
                rb_q     <= ir[22:19];
                rc_q     <= ir[18:15];
            end
            if (state_q == S_T5)
                instr_cnt_q <= instr_cnt_q + 16'd1;
        end
    end

    // Moore output decode from the current state and latched fields.
    always_comb begin
        enable          = 32'd0;
        busSelect       = 32'd0;
        MR_Read         = 1'b0;
        pc_inc          = 1'b0;
        Control_Signals = 4'd0;
        done            = 1'b0;
        err             = 1'b0;
        case (state_q)
            S_T0: begin
                busSelect = SEL_PC;
                enable    = SEL_MAR;
                pc_inc    = 1'b1;
            end
            S_T1: begin
                MR_Read = 1'b1;
                enable  = SEL_MDR;
            end
            S_T2: begin
                busSelect = SEL_MDR;
                enable    = SEL_IR;
            end
            S_T3: begin
                if (op_legal) begin
                    busSelect = {28'd0, rb_q};
                    enable    = SEL_Y;
                end
            end
            S_T4: begin
                busSelect       = {28'd0, rc_q};
                enable          = SEL_Z;
                Control_Signals = alu_op;
            end
            S_T5: begin
                busSelect = SEL_ZLO;
                enable    = {28'd0, ra_q};
                done      = 1'b1;
            end
            S_HALT: err = 1'b1;
            default: ;
        endcase
    end

    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_seq_control_unit.sv
// tb/tb_seq_control_unit.sv - randomized self-checking bench for seq_control_unit
module tb_seq_control_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic        run;
    logic [31:0] ir;
    logic        mem_rdy;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic        MR_Read;
    logic        pc_inc;
    logic [3:0]  Control_Signals;
    logic        done;
    logic        err;
    logic [15:0] instr_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] ref_cnt = 16'd0;

    typedef struct packed {
        logic [31:0] en;
        logic [31:0] bus;
        logic        mr;
        logic        pc;
        logic [3:0]  alu;
        logic        dn;
        logic        er;
    } exp_t;

    typedef exp_t exp_q_t[$];

    seq_control_unit dut (
        .clk             (clk),
        .clr             (clr),
        .run             (run),
        .ir              (ir),
        .mem_rdy         (mem_rdy),
        .enable          (enable),
        .busSelect       (busSelect),
        .MR_Read         (MR_Read),
        .pc_inc          (pc_inc),
        .Control_Signals (Control_Signals),
        .done            (done),
        .err             (err),
        .instr_cnt       (instr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, required summary before time limit");
        $fatal(1);
    end

    function automatic exp_t mk(input int en, input int bus, input bit mr, input bit pc,
                                input int alu, input bit dn, input bit er);
        exp_t e;
        e.en  = 32'(en);
        e.bus = 32'(bus);
        e.mr  = mr;
        e.pc  = pc;
        e.alu = 4'(alu);
        e.dn  = dn;
        e.er  = er;
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o = {enable, busSelect, MR_Read, pc_inc, Control_Signals, done, err};
        return o;
    endfunction

    // Reference: the per-cycle output trace of one instruction starting at T0.
    function automatic exp_q_t build(input logic [31:0] instr, input int waits);
        exp_q_t q;
        logic [4:0] op;
        int alu;
        op = instr[31:27];
        q.push_back(mk(25, 20, 0, 1, 0, 0, 0));
        for (int k = 0; k < waits + 1 && k < 15; k++)
            q.push_back(mk(21, 0, 1, 0, 0, 0, 0));
        if (waits >= 15) begin
            q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
            return q;
        end
        q.push_back(mk(23, 21, 0, 0, 0, 0, 0));
        case (op)
            5'b00011: alu = 1;
            5'b00100: alu = 2;
            5'b00101: alu = 3;
            5'b00110: alu = 4;
            default:  alu = 0;
        endcase
        if (alu == 0) begin
            q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
            return q;
        end
        q.push_back(mk(27, int'(instr[22:19]), 0, 0, 0, 0, 0));
        q.push_back(mk(24, int'(instr[18:15]), 0, 0, alu, 0, 0));
        q.push_back(mk(int'(instr[26:23]), 19, 0, 0, 0, 1, 0));
        return q;
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] v;
        v = $urandom;
        v[31:27] = 5'($urandom_range(3, 6));
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        ref_cnt = 16'd0;
    endtask

    // Drive one instruction and compare every cycle against the reference trace.
    task automatic exec(input logic [31:0] instr, input int waits, input bit from_idle,
                        input bit run_next, input int stop_idx, input string tag,
                        output int done_idx);
        exp_q_t q;
        exp_t   obs;
        int     n_t1;
        q = build(instr, waits);
        n_t1 = (waits < 15) ? waits + 1 : 15;
        done_idx = -1;
        if (from_idle) begin
            @(negedge clk);
            obs = observe();
            checks++;
            if (obs !== '0 || instr_cnt !== ref_cnt) begin
                errors++;
                $display("FAIL %s idle: got outputs=%h cnt=%h, required outputs=0 cnt=%h",
                         tag, obs, instr_cnt, ref_cnt);
            end
            run = 1'b1;
            ir = instr;
            mem_rdy = 1'($urandom);
            @(posedge clk);
        end
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            obs = observe();
            checks++;
            if (obs !== q[i] || instr_cnt !== ref_cnt) begin
                errors++;
                $display("FAIL %s cycle %0d: got en=%0d bus=%0d mr=%b pc=%b alu=%0d done=%b err=%b cnt=%h, required en=%0d bus=%0d mr=%b pc=%b alu=%0d done=%b err=%b cnt=%h",
                         tag, i, obs.en, obs.bus, obs.mr, obs.pc, obs.alu, obs.dn, obs.er, instr_cnt,
                         q[i].en, q[i].bus, q[i].mr, q[i].pc, q[i].alu, q[i].dn, q[i].er, ref_cnt);
            end
            if (q[i].dn) begin
                done_idx = i;
                ref_cnt = ref_cnt + 16'd1;
            end
            if (i == stop_idx) begin
                clr = 1'b0;
                run = 1'b1;
                mem_rdy = 1'($urandom);
                return;
            end
            ir = (i <= n_t1 + 1) ? instr : $urandom;
            mem_rdy = (i >= 1 && i <= n_t1) ? 1'(i - 1 == waits) : 1'($urandom);
            run = q[i].dn ? run_next : 1'($urandom);
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        exp_t obs;
        clr = 1'b0;
        run = 1'b1;
        ir = $urandom;
        mem_rdy = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            obs = observe();
            checks++;
            if (obs !== '0 || instr_cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_hold: got outputs=%h cnt=%h, required 0", obs, instr_cnt);
            end
        end
        run = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        obs = observe();
        checks++;
        if (obs !== '0 || instr_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_idle: got outputs=%h cnt=%h, required 0", obs, instr_cnt);
        end
        ref_cnt = 16'd0;
    endtask

    task automatic test_add();
        int d;
        exec(32'h18A28000, 0, 1'b1, 1'b0, -1, "add", d);
        checks++;
        if (d !== 5) begin
            errors++;
            $display("FAIL add_done_cycle: got %0d, required 5", d);
        end
        @(negedge clk);
        checks++;
        if (instr_cnt !== 16'd1) begin
            errors++;
            $display("FAIL add_cnt: got %h, required 0001", instr_cnt);
        end
    endtask

    task automatic test_mem_wait();
        int d;
        exec(rand_legal(), 3, 1'b1, 1'b0, -1, "mem_wait", d);
        checks++;
        if (d !== 8) begin
            errors++;
            $display("FAIL mem_wait_done_cycle: got %0d, required 8", d);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        for (int n = 0; n < 3; n++) begin
            exec(rand_legal(), 0, n == 0, n != 2, -1, "back_to_back", d);
            checks++;
            if (d !== 5) begin
                errors++;
                $display("FAIL back_to_back_done_cycle %0d: got %0d, required 5", n, d);
            end
        end
    endtask

    task automatic test_random();
        int d;
        bit prev_run;
        bit nxt;
        prev_run = 1'b0;
        for (int n = 0; n < 40; n++) begin
            nxt = (n == 39) ? 1'b0 : 1'($urandom);
            exec(rand_legal(), int'($urandom_range(0, 6)), !prev_run, nxt, -1, "random", d);
            prev_run = nxt;
        end
    endtask

    task automatic test_timeout();
        int d;
        exp_t obs;
        exec(rand_legal(), 15 + int'($urandom_range(0, 5)), 1'b1, 1'b0, -1, "timeout", d);
        repeat (5) begin
            @(negedge clk);
            obs = observe();
            checks++;
            if (obs !== mk(0, 0, 0, 0, 0, 0, 1) || instr_cnt !== ref_cnt) begin
                errors++;
                $display("FAIL timeout_halt_hold: got outputs=%h cnt=%h, required err only cnt=%h",
                         obs, instr_cnt, ref_cnt);
            end
            run = 1'($urandom);
            mem_rdy = 1'($urandom);
            @(posedge clk);
        end
        do_reset();
        obs = observe();
        checks++;
        if (obs !== '0 || instr_cnt !== 16'd0) begin
            errors++;
            $display("FAIL timeout_reset: got outputs=%h cnt=%h, required 0", obs, instr_cnt);
        end
    endtask

    task automatic test_illegal();
        int d;
        logic [31:0] v;
        logic [4:0] ops [4];
        ops[0] = 5'b11111;
        ops[1] = 5'b00000;
        ops[2] = 5'b00111;
        ops[3] = 5'b00010;
        for (int n = 0; n < 4; n++) begin
            exec(rand_legal(), 0, 1'b1, 1'b0, -1, "illegal_pre", d);
            v = $urandom;
            v[31:27] = ops[n];
            exec(v, int'($urandom_range(0, 2)), 1'b1, 1'b0, -1, "illegal", d);
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || Control_Signals !== 4'd0 || instr_cnt !== ref_cnt) begin
                errors++;
                $display("FAIL illegal_halt op=%b: got err=%b alu=%0d cnt=%h, required err=1 alu=0 cnt=%h",
                         ops[n], err, Control_Signals, instr_cnt, ref_cnt);
            end
            do_reset();
        end
    endtask

    task automatic test_reset_mid();
        int d;
        exp_t obs;
        exec(rand_legal(), 0, 1'b1, 1'b0, -1, "reset_mid_pre", d);
        exec(rand_legal(), 0, 1'b1, 1'b1, 4, "reset_mid", d);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            obs = observe();
            checks++;
            if (obs !== '0 || instr_cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_mid: got outputs=%h cnt=%h, required 0", obs, instr_cnt);
            end
        end
        clr = 1'b1;
        run = 1'b0;
        ref_cnt = 16'd0;
    endtask

    task automatic test_wrap();
        int d;
        @(posedge clk);
        @(negedge clk);
        dut.instr_cnt_q = 16'hFFFF;
        ref_cnt = 16'hFFFF;
        exec(rand_legal(), 0, 1'b1, 1'b0, -1, "wrap", d);
        @(negedge clk);
        checks++;
        if (instr_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL wrap: got %h, required 0000", instr_cnt);
        end
    endtask

    initial begin
        clr = 1'b0;
        run = 1'b0;
        ir = 32'd0;
        mem_rdy = 1'b0;
        test_reset();
        test_add();
        test_mem_wait();
        test_back_to_back();
        test_random();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
